// File: rtl/dht11_responder.sv
// Device end of the DHT11 single-wire protocol: detects a host start pulse and answers with a 40-bit frame.
// Optional macro DHT11_RESPONDER_CHECKSUM_FAULT_EN adds inject_checksum_error_i to corrupt the checksum LSB.
module dht11_responder #(
    parameter int CLK_FREQ_MHZ  = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int RESP_LOW_US   = 80,
    parameter int RESP_HIGH_US  = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 26,
    parameter int BIT1_HIGH_US  = 70
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
`ifdef DHT11_RESPONDER_CHECKSUM_FAULT_EN
    input  logic       inject_checksum_error_i,
`endif
    input  logic       enable_i,
    input  logic       line_in_i,
    input  logic [7:0] humidity_int_i,
    input  logic [7:0] humidity_dec_i,
    input  logic [7:0] temperature_int_i,
    input  logic [7:0] temperature_dec_i,
    output logic       line_pull_low_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_START_LOW, S_WAIT_RESP, S_RESP_LOW,
        S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
    } state_t;

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_FREQ_MHZ - 1);
    localparam logic [14:0]   START_MIN  = 15'(START_MIN_US);
    localparam logic [14:0]   RESP_DELAY = 15'(RESP_DELAY_US);
    localparam logic [14:0]   RESP_LOW   = 15'(RESP_LOW_US);
    localparam logic [14:0]   RESP_HIGH  = 15'(RESP_HIGH_US);
    localparam logic [14:0]   BIT_LOW    = 15'(BIT_LOW_US);
    localparam logic [14:0]   BIT0_HIGH  = 15'(BIT0_HIGH_US);
    localparam logic [14:0]   BIT1_HIGH  = 15'(BIT1_HIGH_US);
    localparam logic [14:0]   CNT_MAX    = 15'h7fff;

    state_t         state_q, state_d;
    logic [1:0]     sync_q, sync_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [14:0]    cnt_q, cnt_d;
    logic [39:0]    shift_q, shift_d;
    logic [5:0]     idx_q, idx_d;
    logic           done_q, done_d;

    logic           line_s;
    logic           us_tick;
    logic [14:0]    dur;
    logic           phase_end;
    logic [7:0]     csum;

    assign line_s  = sync_q[1];
    assign us_tick = (pre_q == PRE_LAST);

    always_comb begin
        csum = humidity_int_i + humidity_dec_i + temperature_int_i + temperature_dec_i;
`ifdef DHT11_RESPONDER_CHECKSUM_FAULT_EN
        if (inject_checksum_error_i) csum = csum ^ 8'h01;
`endif
    end

    // A phase ends on the Nth microsecond tick after entry, so count reaches N-1 on that tick.
    always_comb begin
        dur = CNT_MAX;
        case (state_q)
            S_WAIT_RESP: dur = RESP_DELAY;
            S_RESP_LOW:  dur = RESP_LOW;
            S_RESP_HIGH: dur = RESP_HIGH;
            S_BIT_LOW:   dur = BIT_LOW;
            S_BIT_HIGH:  dur = shift_q[39] ? BIT1_HIGH : BIT0_HIGH;
            S_END_LOW:   dur = BIT_LOW;
            default:     dur = CNT_MAX;
        endcase
        phase_end = us_tick && (cnt_q == dur - 15'd1);
    end

    // FSM: state register
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (enable_i && !line_s) state_d = S_START_LOW;
            S_START_LOW: if (line_s) state_d = (cnt_q >= START_MIN) ? S_WAIT_RESP : S_IDLE;
            S_WAIT_RESP: if (phase_end) state_d = S_RESP_LOW;
            S_RESP_LOW:  if (phase_end) state_d = S_RESP_HIGH;
            S_RESP_HIGH: if (phase_end) state_d = S_BIT_LOW;
            S_BIT_LOW:   if (phase_end) state_d = S_BIT_HIGH;
            S_BIT_HIGH:  if (phase_end) state_d = (idx_q == 6'd39) ? S_END_LOW : S_BIT_LOW;
            S_END_LOW:   if (phase_end) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        line_pull_low_o = (state_q == S_RESP_LOW) || (state_q == S_BIT_LOW) ||
                          (state_q == S_END_LOW);
        busy_o          = (state_q != S_IDLE) && (state_q != S_START_LOW);
        frame_done_o    = done_q;
    end

    always_comb begin
        sync_d  = {sync_q[0], line_in_i};
        pre_d   = us_tick ? '0 : pre_q + PW'(1);
        if (state_d != state_q)              cnt_d = '0;
        else if (us_tick && cnt_q != CNT_MAX) cnt_d = cnt_q + 15'd1;
        else                                 cnt_d = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        // The frame is captured once at acceptance; later input changes cannot reach the wire.
        if (state_q == S_START_LOW && state_d == S_WAIT_RESP) begin
            shift_d = {humidity_int_i, humidity_dec_i, temperature_int_i, temperature_dec_i, csum};
            idx_d   = '0;
        end else if (state_q == S_BIT_HIGH && phase_end) begin
            shift_d = {shift_q[38:0], 1'b0};
            idx_d   = idx_q + 6'd1;
        end
        done_d  = (state_q == S_END_LOW) && phase_end;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            sync_q  <= 2'b11;
            pre_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

endmodule
